// File: rtl/zbuf_arbiter.sv
// Round-robin arbiter with urgency and anti-starvation tiers, feeding one
// registered valid/ready slot toward the z-buffer from four pixel FIFOs.
module zbuf_arbiter #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int MEM_LENGTH   = 8,
  parameter int URGENT_LEVEL = 6,
  parameter int MAX_WAIT     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_1,
  input  logic                   req_2,
  input  logic                   req_3,
  input  logic                   req_4,
  input  logic [MEM_LENGTH-1:0]  fill_1,
  input  logic [MEM_LENGTH-1:0]  fill_2,
  input  logic [MEM_LENGTH-1:0]  fill_3,
  input  logic [MEM_LENGTH-1:0]  fill_4,
  input  logic [PIXEL_WIDTH-1:0] pix_in_1,
  input  logic [PIXEL_WIDTH-1:0] pix_in_2,
  input  logic [PIXEL_WIDTH-1:0] pix_in_3,
  input  logic [PIXEL_WIDTH-1:0] pix_in_4,
  input  logic                   rdy_z_buffer,
  output logic                   pop_1,
  output logic                   pop_2,
  output logic                   pop_3,
  output logic                   pop_4,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic                   send_z_buffer,
  output logic [1:0]             grant_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             req, starved, urgent, pop_vec;
  logic [MEM_LENGTH-1:0]  fill   [4];
  logic [PIXEL_WIDTH-1:0] pix_in [4];
  logic [3:0]             wait_cnt [4];
  logic [1:0]             ptr, winner;
  logic                   load_ok, grant;

  assign req       = {req_4, req_3, req_2, req_1};
  assign fill[0]   = fill_1;
  assign fill[1]   = fill_2;
  assign fill[2]   = fill_3;
  assign fill[3]   = fill_4;
  assign pix_in[0] = pix_in_1;
  assign pix_in[1] = pix_in_2;
  assign pix_in[2] = pix_in_3;
  assign pix_in[3] = pix_in_4;

  // First set member found scanning upward from base+1, wrapping.
  function automatic logic [1:0] rr_pick(input logic [3:0] set, input logic [1:0] base);
    logic [1:0] idx, res;
    logic       found;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && set[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      starved[i] = req[i] && (wait_cnt[i] == 4'(MAX_WAIT));
      urgent[i]  = req[i] && fill[i][URGENT_LEVEL-1];
    end
    if (|starved)     winner = rr_pick(starved, ptr);
    else if (|urgent) winner = rr_pick(urgent, ptr);
    else              winner = rr_pick(req, ptr);
  end

  always_comb begin
    state_nxt = state;
    pop_vec   = '0;
    load_ok   = (state == EMPTY) || rdy_z_buffer;
    grant     = reset && load_ok && (|req);
    if (grant) pop_vec[winner] = 1'b1;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (rdy_z_buffer && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign pop_1         = pop_vec[0];
  assign pop_2         = pop_vec[1];
  assign pop_3         = pop_vec[2];
  assign pop_4         = pop_vec[3];
  assign send_z_buffer = (state == FULL);

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // ptr resets to 3 so the first round-robin search begins at FIFO 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_out  <= '0;
      grant_id <= '0;
      ptr      <= 2'd3;
      for (int unsigned i = 0; i < 4; i++) wait_cnt[i] <= '0;
    end else begin
      if (grant) begin
        pix_out  <= pix_in[winner];
        grant_id <= winner;
        ptr      <= winner;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (!req[i] || (grant && winner == 2'(i)))
          wait_cnt[i] <= '0;
        else if (grant && wait_cnt[i] < 4'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_zbuf_arbiter.sv
// Bench for zbuf_arbiter: directed scenarios plus random traffic, checked each
// cycle against a behavioural model of the arbitration rules.
module tb_zbuf_arbiter;
  localparam int PW   = 16;
  localparam int ML   = 8;
  localparam int UL   = 6;
  localparam int MW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [ML-1:0] fillv [4];
  logic [PW-1:0] pixv  [4];
  logic          rdy;
  logic          pop_1, pop_2, pop_3, pop_4;
  logic [PW-1:0] pix_out;
  logic          send_z_buffer;
  logic [1:0]    grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  zbuf_arbiter #(.PIXEL_WIDTH(PW), .MEM_LENGTH(ML), .URGENT_LEVEL(UL), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .req_1(req[0]), .req_2(req[1]), .req_3(req[2]), .req_4(req[3]),
    .fill_1(fillv[0]), .fill_2(fillv[1]), .fill_3(fillv[2]), .fill_4(fillv[3]),
    .pix_in_1(pixv[0]), .pix_in_2(pixv[1]), .pix_in_3(pixv[2]), .pix_in_4(pixv[3]),
    .rdy_z_buffer(rdy),
    .pop_1(pop_1), .pop_2(pop_2), .pop_3(pop_3), .pop_4(pop_4),
    .pix_out(pix_out), .send_z_buffer(send_z_buffer), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot occupancy, held word, last winner, wait counts.
  bit            m_full = 0;
  logic [PW-1:0] m_pix  = '0;
  int            m_gid  = 0;
  int            m_ptr  = 3;
  int            m_wait [4] = '{0, 0, 0, 0};

  function automatic int model_winner();
    int  idx;
    bit  el;
    for (int t = 0; t < 3; t++)
      for (int k = 1; k <= 4; k++) begin
        idx = (m_ptr + k) % 4;
        case (t)
          0:       el = req[idx] && (m_wait[idx] == MW);
          1:       el = req[idx] && fillv[idx][UL-1];
          default: el = req[idx];
        endcase
        if (el) return idx;
      end
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    int         win;
    logic [3:0] exp_pop;
    win     = -1;
    exp_pop = '0;
    if (reset && (!m_full || rdy) && req != 4'b0) begin
      win = model_winner();
      exp_pop[win] = 1'b1;
    end
    chk("pop", {28'b0, pop_4, pop_3, pop_2, pop_1}, {28'b0, exp_pop});
    chk("send", {31'b0, send_z_buffer}, {31'b0, m_full});
    chk("pix_out", {16'b0, pix_out}, {16'b0, m_pix});
    chk("grant_id", {30'b0, grant_id}, 32'(m_gid));
    if (!reset) begin
      m_full = 0; m_pix = '0; m_gid = 0; m_ptr = 3;
      for (int i = 0; i < 4; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || i == win) m_wait[i] = 0;
        else if (win >= 0 && m_wait[i] < MW) m_wait[i]++;
      end
      if (win >= 0) begin
        m_full = 1; m_pix = pixv[win]; m_gid = win; m_ptr = win;
      end else if (rdy) m_full = 0;
    end
  end

  // Record which FIFO the DUT actually popped, for literal sequence checks.
  int cap[$];
  always @(negedge clk) begin
    if (pop_1) cap.push_back(0);
    if (pop_2) cap.push_back(1);
    if (pop_3) cap.push_back(2);
    if (pop_4) cap.push_back(3);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all_fill(input logic [ML-1:0] f);
    for (int i = 0; i < 4; i++) fillv[i] = f;
  endtask

  int rr_exp[5]  = '{0, 1, 2, 3, 0};
  int urg_exp[8] = '{2, 2, 2, 2, 3, 0, 1, 2};

  initial begin
    int occ;
    reset = 1'b0; req = 4'hF; rdy = 1'b1;
    set_all_fill(8'h01);
    for (int i = 0; i < 4; i++) pixv[i] = 16'(i + 1);

    // Reset held with all requests present
    cyc(3);
    chk("rst_send", {31'b0, send_z_buffer}, 32'd0);
    chk("rst_pix", {16'b0, pix_out}, 32'd0);
    chk("rst_cap", 32'(cap.size()), 32'd0);

    // Round-robin
    cap.delete();
    reset = 1'b1;
    cyc(4);
    chk("rr_pix4", {16'b0, pix_out}, 32'h0004);
    cyc(1);
    chk("rr_len", 32'(cap.size()), 32'd5);
    for (int i = 0; i < 5 && i < cap.size(); i++) chk("rr_order", 32'(cap[i]), 32'(rr_exp[i]));

    // Drain, then backpressure on a single requester
    req = 4'h0; rdy = 1'b1;
    cyc(1);
    cap.delete();
    req = 4'b0010; pixv[1] = 16'h00AA; rdy = 1'b0;
    cyc(5);
    chk("bp_pops", 32'(cap.size()), 32'd1);
    chk("bp_pix", {16'b0, pix_out}, 32'h00AA);
    chk("bp_send", {31'b0, send_z_buffer}, 32'd1);
    rdy = 1'b1;
    cyc(1);
    chk("bp_release_pops", 32'(cap.size()), 32'd2);

    // Urgency with starvation
    cap.delete();
    req = 4'hF; set_all_fill(8'h01); fillv[2] = 8'h3F;
    for (int i = 0; i < 4; i++) pixv[i] = 16'(i + 1);
    cyc(8);
    chk("urg_len", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk("urg_order", 32'(cap[i]), 32'(urg_exp[i]));

    // Mid-operation reset
    set_all_fill(8'h01);
    rdy = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1; req = 4'h0;
    chk("mr_send", {31'b0, send_z_buffer}, 32'd0);
    chk("mr_pix", {16'b0, pix_out}, 32'd0);
    cap.delete();
    req = 4'b1000; rdy = 1'b1;
    cyc(1);
    req = 4'hF;
    cyc(1);
    chk("mr_len", 32'(cap.size()), 32'd2);
    if (cap.size() >= 2) begin
      chk("mr_first", 32'(cap[0]), 32'd3);
      chk("mr_second", 32'(cap[1]), 32'd0);
    end

    // Idle: slot holds FIFO 1's word, then drains
    cap.delete();
    req = 4'h0; rdy = 1'b0;
    cyc(1);
    rdy = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      rdy = ~rdy;
      cyc(1);
    end
    chk("idle_pops", 32'(cap.size()), 32'd0);
    chk("idle_send", {31'b0, send_z_buffer}, 32'd0);
    chk("idle_pix", {16'b0, pix_out}, 32'h0001);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        req[i]  = ($urandom_range(0, 2) != 0);
        occ     = req[i] ? int'($urandom_range(1, ML)) : 0;
        fillv[i] = 8'((9'd1 << occ) - 9'd1);
        pixv[i] = 16'($urandom);
      end
      cyc(1);
    end

    req = 4'h0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zbuf_arbiter.md
# zbuf_arbiter

Round-robin arbiter with urgency and anti-starvation that shares the single z-buffer input port between the four pixel FIFOs of the fifo/contention-tree stage. It inspects each FIFO's request and fill level, pops one head pixel per cycle from the winning FIFO, and holds it in a registered valid/ready output slot toward the z-buffer. It sequences the FIFO pops and the z-buffer handshake; it stores no pixels beyond the one-word output slot.

## Interface
- PIXEL_WIDTH, 16, pixel word width
- MEM_LENGTH, 8, FIFO depth; width of the thermometer-coded fill vectors
- URGENT_LEVEL, 6, FIFO is urgent when its occupancy is ≥ URGENT_LEVEL (fill_i[URGENT_LEVEL-1]=1); range 1..MEM_LENGTH
- MAX_WAIT, 4, lost arbitrations before a requester counts as starved; range 1..15
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; asserted when 0
- req_1..req_4  in  1 each  FIFO i non-empty; pix_in_i is valid
- fill_1..fill_4  in  MEM_LENGTH each  thermometer occupancy; bit k=1 ⇔ ≥k+1 entries
- pix_in_1..pix_in_4  in  PIXEL_WIDTH each  FIFO i head word, first-word-fall-through
- rdy_z_buffer  in  1  z-buffer accepts pix_out this cycle
- pop_1..pop_4  out  1 each  combinational dequeue strobe to FIFO i
- pix_out  out  PIXEL_WIDTH  registered pixel to the z-buffer
- send_z_buffer  out  1  registered; pix_out is valid
- grant_id  out  2  registered; source FIFO of pix_out (0 = FIFO 1)

## Operation
- Two-state FSM on the output slot:
  - EMPTY: send_z_buffer=0.
  - FULL: send_z_buffer=1.
- load_ok = (state==EMPTY) | rdy_z_buffer.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on rdy & grant, or on !rdy.
  - FULL→EMPTY on rdy & no grant.
  - EMPTY→EMPTY otherwise.
- Grant occurs when load_ok & any req_i. Exactly one pop_i pulses, for the winner. The winner's pix_in_i, the winner's index and send=1 are registered at the edge.
- Winner selection uses a three-tier priority. Within a tier, round-robin searches from index (ptr+1) mod 4 upward and wraps.
  - Tier 1: starved = req_i & (wait_i == MAX_WAIT).
  - Tier 2: urgent = req_i & fill_i[URGENT_LEVEL-1].
  - Tier 3: any req_i.
- ptr is a 2-bit register holding the last granted index. It is updated to the winner on every grant.
- wait_i is a 4-bit counter per requester. It is updated only on grant cycles:
  - cleared if i wins or req_i=0;
  - otherwise incremented, saturating at MAX_WAIT.
- On non-grant cycles, wait_i is cleared where req_i=0 and otherwise holds.
- pop_i is never asserted when req_i=0 or when reset=0.
- With no grant, pix_out and grant_id hold their last values.

## Timing
- Reset values (reset=0 at an edge):
  - pix_out=0, send_z_buffer=0, grant_id=0, state EMPTY;
  - ptr=3, so the first search starts at FIFO 1;
  - all wait_i=0;
  - pop_1..4 forced 0 while reset=0.
- Reset mid-transfer drops the held pixel: the word is lost, no pop is issued, and the slot clears in the same edge.
- Latency:
  - req_i rising in cycle t with the slot EMPTY gives pop_i=1 in cycle t and send_z_buffer=1 with pix_out=pix_in_i from t+1.
  - pop_i depends combinationally on req, fill and rdy_z_buffer in the same cycle.
- Throughput: one pixel per cycle while rdy_z_buffer=1 and any req_i=1. A transfer and a new grant occur in the same cycle.
- Backpressure: with send=1 and rdy=0, pix_out, grant_id and send hold, and no pop occurs.
- A z-buffer transfer completes at an edge where send_z_buffer & rdy_z_buffer.
- rdy_z_buffer while EMPTY has no effect.
- req_i dropping in the same cycle a grant is evaluated removes i from contention that cycle.
- fill_i is sampled only in grant cycles. A fill change takes effect immediately.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with all req=1 and rdy=1 → pop_1..4=0, send_z_buffer=0, pix_out=0, grant_id=0 throughout.
- **Round-robin:** after reset, req_1..4=1, fill=8'h01, pix_in_i=16'h000i, rdy=1 → pops 1,2,3,4,1 in consecutive cycles; pix_out=0001,0002,0003,0004 one cycle later each; send stays 1.
- **Backpressure:** single req_2 with pix_in_2=16'h00AA, rdy=0 for 5 cycles → one pop_2, pix_out=00AA held with send=1 and no further pops. Then rdy=1 for one cycle → transfer plus pop_2 in the same cycle.
- **Urgency with starvation:** all req=1, fill_3=8'h3F, others 8'h01, MAX_WAIT=4, rdy=1 → grant order 3,3,3,3,4,1,2,3.
- **Mid-operation reset:** slot FULL with rdy=0, then reset=0 for one edge → next cycle send=0, pix_out=0. After release with req_4 only → pop_4 first; the next grant with all req searches from FIFO 1.
- **Idle/empty:** all req=0 with rdy toggling → no pops. A FULL slot drains after one rdy cycle to send=0, and pix_out holds its last value.
